// File: rtl/sc_level_pkg.sv
// Shared types and constants for the level sequencer.
package sc_level_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRANSITION = 2'd1,
    WON        = 2'd2
  } state_e;

  localparam int MODE_SATURATE = 0;
  localparam int MODE_WRAP     = 1;

endpackage

// File: rtl/sc_edge_detect_low.sv
// Falling-edge detector for active-low strobes.
module sc_edge_detect_low #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig_n,
  output logic o_req
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= RESET_VAL;
    else          r_q <= i_sig_n;
  end

  assign o_req = r_q & ~i_sig_n;

endmodule

// File: rtl/sc_level_sequencer.sv
// Level counter: one advance per strobe, busy window, WIN or wrap.
module sc_level_sequencer
  import sc_level_pkg::*;
#(
  parameter int LEVEL_WIDTH       = 3,
  parameter int LEVEL_MAX         = 7,
  parameter int START_LEVEL       = 0,
  parameter int WRAP_MODE         = MODE_SATURATE,
  parameter int TRANSITION_CYCLES = 4
) (
  input  logic                   SC_levelseq_CLOCK_50,
  input  logic                   SC_levelseq_RESET_InLow,
  input  logic                   SC_levelseq_advance_InLow,
  input  logic                   SC_levelseq_clear_InHigh,
  output logic [LEVEL_WIDTH-1:0] SC_levelseq_level_OutBus,
  output logic                   SC_levelseq_levelup_OutHigh,
  output logic                   SC_levelseq_busy_OutHigh,
  output logic                   SC_levelseq_win_OutHigh
);

  localparam int TW = $clog2(TRANSITION_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TRANSITION_CYCLES - 1);
  localparam logic [LEVEL_WIDTH-1:0] L_MAX = LEVEL_WIDTH'(LEVEL_MAX);
  localparam logic [LEVEL_WIDTH-1:0] L_START = LEVEL_WIDTH'(START_LEVEL);

  logic                   w_req;
  state_e                 r_state;
  logic [TW-1:0]          r_timer;
  logic [LEVEL_WIDTH-1:0] r_level;
  logic                   r_levelup;
  logic                   r_busy;
  logic                   r_win;

  sc_edge_detect_low #(
    .RESET_VAL(1'b1)
  ) u_adv_edge (
    .i_clk   (SC_levelseq_CLOCK_50),
    .i_rst_n (SC_levelseq_RESET_InLow),
    .i_sig_n (SC_levelseq_advance_InLow),
    .o_req   (w_req)
  );

  always_ff @(posedge SC_levelseq_CLOCK_50 or negedge SC_levelseq_RESET_InLow) begin
    if (!SC_levelseq_RESET_InLow) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_level   <= L_START;
      r_levelup <= 1'b0;
      r_busy    <= 1'b0;
      r_win     <= 1'b0;
    end else begin
      r_levelup <= 1'b0;
      if (SC_levelseq_clear_InHigh) begin
        r_state <= IDLE;
        r_timer <= '0;
        r_level <= L_START;
        r_busy  <= 1'b0;
        r_win   <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_req) begin
              if (r_level < L_MAX) begin
                r_level   <= r_level + 1'b1;
                r_levelup <= 1'b1;
                r_timer   <= TMR_LOAD;
                r_busy    <= 1'b1;
                r_state   <= TRANSITION;
              end else if (WRAP_MODE == MODE_WRAP) begin
                r_level   <= L_START;
                r_levelup <= 1'b1;
                r_timer   <= TMR_LOAD;
                r_busy    <= 1'b1;
                r_state   <= TRANSITION;
              end else begin
                r_win   <= 1'b1;
                r_state <= WON;
              end
            end
          end
          // Requests here are dropped, not queued.
          TRANSITION: begin
            if (r_timer == '0) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          WON: begin
            r_win  <= 1'b1;
            r_busy <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SC_levelseq_level_OutBus    = r_level;
  assign SC_levelseq_levelup_OutHigh = r_levelup;
  assign SC_levelseq_busy_OutHigh    = r_busy;
  assign SC_levelseq_win_OutHigh     = r_win;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Scoreboard bench: saturating (A) and wrapping (B) sequencer instances.
module tb_sc_level_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic adv_a, adv_b, clr_a, clr_b;
  logic [2:0] lvl_a, lvl_b;
  logic lu_a, lu_b, busy_a, busy_b, win_a, win_b;

  int checks = 0;
  int errors = 0;
  logic [2:0] qa[$];
  logic [2:0] qb[$];

  always #5 clk = ~clk;

  sc_level_sequencer u_a (
    .SC_levelseq_CLOCK_50        (clk),
    .SC_levelseq_RESET_InLow     (rst_n),
    .SC_levelseq_advance_InLow   (adv_a),
    .SC_levelseq_clear_InHigh    (clr_a),
    .SC_levelseq_level_OutBus    (lvl_a),
    .SC_levelseq_levelup_OutHigh (lu_a),
    .SC_levelseq_busy_OutHigh    (busy_a),
    .SC_levelseq_win_OutHigh     (win_a)
  );

  sc_level_sequencer #(
    .LEVEL_WIDTH(3),
    .LEVEL_MAX(5),
    .START_LEVEL(2),
    .WRAP_MODE(1),
    .TRANSITION_CYCLES(4)
  ) u_b (
    .SC_levelseq_CLOCK_50        (clk),
    .SC_levelseq_RESET_InLow     (rst_n),
    .SC_levelseq_advance_InLow   (adv_b),
    .SC_levelseq_clear_InHigh    (clr_b),
    .SC_levelseq_level_OutBus    (lvl_b),
    .SC_levelseq_levelup_OutHigh (lu_b),
    .SC_levelseq_busy_OutHigh    (busy_b),
    .SC_levelseq_win_OutHigh     (win_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every levelup pulse must match the next queued level.
  always @(negedge clk) begin
    if (rst_n && lu_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL mon_a spurious levelup: level %0d, none expected", lvl_a);
      end else begin
        logic [2:0] e;
        e = qa.pop_front();
        if (lvl_a != e) begin
          errors++;
          $display("FAIL mon_a level: got %0d expected %0d", lvl_a, e);
        end
      end
    end
    if (rst_n && lu_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL mon_b spurious levelup: level %0d, none expected", lvl_b);
      end else begin
        logic [2:0] e;
        e = qb.pop_front();
        if (lvl_b != e) begin
          errors++;
          $display("FAIL mon_b level: got %0d expected %0d", lvl_b, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One-cycle low pulse on A; exp < 0 means no advance expected.
  task automatic pulse_a(input int exp);
    @(negedge clk);
    adv_a = 1'b0;
    if (exp >= 0) qa.push_back(3'(exp));
    @(negedge clk);
    adv_a = 1'b1;
  endtask

  task automatic pulse_b(input int exp);
    @(negedge clk);
    adv_b = 1'b0;
    if (exp >= 0) qb.push_back(3'(exp));
    @(negedge clk);
    adv_b = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nl;
    rst_n = 1'b0;
    adv_a = 1'b0;
    adv_b = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    adv_a = 1'b1;
    adv_b = 1'b1;
    cyc(3);
    check("rst_level_a", lvl_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_win_a", win_a, 0);
    check("rst_levelup_a", lu_a, 0);
    check("rst_level_b", lvl_b, 2);

    // Single advance, strobe held low for 10 cycles
    @(negedge clk);
    adv_a = 1'b0;
    qa.push_back(3'd1);
    @(negedge clk);
    check("adv1_level", lvl_a, 1);
    check("adv1_levelup", lu_a, 1);
    nb = 0;
    nl = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy_a) nb++;
      if (lu_a) nl++;
      @(negedge clk);
    end
    check("adv1_busy_cycles", nb, 4);
    check("adv1_levelup_cycles", nl, 1);
    check("adv1_held_level", lvl_a, 1);
    adv_a = 1'b1;
    pulse_a(2);
    check("adv2_level", lvl_a, 2);
    cyc(6);

    // Second falling edge inside busy window is dropped
    pulse_a(3);
    @(negedge clk);
    adv_a = 1'b0;
    @(negedge clk);
    adv_a = 1'b1;
    cyc(6);
    check("drop_level", lvl_a, 3);
    check("drop_busy", busy_a, 0);

    // Step to LEVEL_MAX, then saturate
    for (int lv = 4; lv <= 7; lv++) begin
      pulse_a(lv);
      cyc(5);
    end
    check("max_level", lvl_a, 7);
    pulse_a(-1);
    check("sat_level", lvl_a, 7);
    check("sat_win", win_a, 1);
    check("sat_busy", busy_a, 0);
    pulse_a(-1);
    cyc(2);
    pulse_a(-1);
    cyc(2);
    check("won_level", lvl_a, 7);
    check("won_win", win_a, 1);
    @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("clr_level", lvl_a, 0);
    check("clr_win", win_a, 0);
    cyc(2);

    // Wrap instance: 2 -> 5 then wrap to START_LEVEL
    for (int lv = 3; lv <= 5; lv++) begin
      pulse_b(lv);
      cyc(5);
    end
    check("wrap_max_level", lvl_b, 5);
    pulse_b(2);
    check("wrap_level", lvl_b, 2);
    check("wrap_busy", busy_b, 1);
    check("wrap_win", win_b, 0);
    cyc(6);
    check("wrap_busy_end", busy_b, 0);
    check("wrap_win_end", win_b, 0);

    // Clear and request on the same edge
    pulse_a(1);
    cyc(6);
    @(negedge clk);
    adv_a = 1'b0;
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("coll_level", lvl_a, 0);
    check("coll_levelup", lu_a, 0);
    cyc(3);
    check("coll_held_level", lvl_a, 0);
    check("coll_held_busy", busy_a, 0);
    adv_a = 1'b1;
    cyc(2);

    // Reset during busy cycle 2
    pulse_a(1);
    @(negedge clk);
    pulse_b(3);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_level_a", lvl_a, 0);
    check("mrst_busy_a", busy_a, 0);
    check("mrst_win_a", win_a, 0);
    check("mrst_levelup_a", lu_a, 0);
    check("mrst_level_b", lvl_b, 2);
    check("mrst_busy_b", busy_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6);
    check("post_rst_level_a", lvl_a, 0);
    check("post_rst_level_b", lvl_b, 2);
    check("queue_a_empty", qa.size(), 0);
    check("queue_b_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_level_sequencer.md
Name: sc_level_sequencer

Overview:
- Parametrised successor to the game's level counter.
- Tracks the current level and turns an active-low "level complete" strobe into exactly one level advance per falling edge.
- Enforces a busy/transition window after each advance, and either saturates with a sticky WIN flag or wraps, depending on mode.
- Sits between the frog/goal detection logic and the speed and display blocks that consume the level bus.

Parameters:
- LEVEL_WIDTH, 3: width of the level bus.
- LEVEL_MAX, 7: highest playable level. Must be < 2**LEVEL_WIDTH.
- START_LEVEL, 0: level loaded on reset and on clear. Must be <= LEVEL_MAX.
- WRAP_MODE, 0: 0 = advance from LEVEL_MAX sets WIN and holds; 1 = advance from LEVEL_MAX wraps to START_LEVEL.
- TRANSITION_CYCLES, 4: number of busy cycles after each advance. Must be >= 1.

Ports:
- SC_levelseq_CLOCK_50  input  1  system clock; all logic on its rising edge.
- SC_levelseq_RESET_InLow  input  1  asynchronous, active-low reset.
- SC_levelseq_advance_InLow  input  1  active-low level-complete strobe; only its falling edge is a request.
- SC_levelseq_clear_InHigh  input  1  synchronous clear to START_LEVEL.
- SC_levelseq_level_OutBus  output  LEVEL_WIDTH  current level (registered).
- SC_levelseq_levelup_OutHigh  output  1  one-cycle pulse on each successful advance or wrap.
- SC_levelseq_busy_OutHigh  output  1  high during the transition window.
- SC_levelseq_win_OutHigh  output  1  sticky game-won flag (WRAP_MODE=0 only).

Behaviour:
- Clocking and reset: one clock, SC_levelseq_CLOCK_50. Reset SC_levelseq_RESET_InLow is asynchronous and active-low.
- Reset values:
  - level = START_LEVEL; levelup = 0; busy = 0; win = 0.
  - State = IDLE; timer = 0; edge register adv_q = 1 (inactive).
- Edge detection:
  - adv_q samples SC_levelseq_advance_InLow every cycle.
  - req = adv_q & ~advance_InLow (combinational).
  - Holding the input low produces exactly one req.
  - Input is synchronous to the clock; no synchroniser in this block.
- States (registered, 2 bits): IDLE, TRANSITION, WON.
- IDLE, on req:
  - If level < LEVEL_MAX: level <= level+1, levelup <= 1, timer <= TRANSITION_CYCLES-1, go to TRANSITION.
  - If level == LEVEL_MAX and WRAP_MODE=1: level <= START_LEVEL, levelup <= 1, timer loaded, go to TRANSITION.
  - If level == LEVEL_MAX and WRAP_MODE=0: win <= 1, level unchanged, no levelup pulse, go to WON.
- TRANSITION:
  - busy = 1.
  - A req arriving here is dropped, not queued.
  - If timer == 0, go to IDLE; otherwise timer decrements.
  - busy is high for exactly TRANSITION_CYCLES cycles, starting the cycle after the advancing edge.
- WON: busy = 0, win = 1, all req ignored; exit only via clear or reset.
- Latency:
  - The level bus and levelup change at the same rising edge that sees req.
  - levelup is high for exactly one cycle.
- Clear:
  - Highest synchronous priority: wins over a simultaneous req in any state.
  - Loads level = START_LEVEL, win = 0, state = IDLE, timer = 0, levelup = 0.
  - adv_q keeps sampling normally, so a low advance held through clear does not re-trigger.
- Arithmetic:
  - Increment is LEVEL_WIDTH wide; overflow cannot occur because of the LEVEL_MAX bound.
  - Timer width is $clog2(TRANSITION_CYCLES+1).
- Reset asserted mid-transition: immediate return to reset values; no pending advance survives.

Decomposition:
- Shared package sc_level_pkg:
  - State encoding localparams: IDLE=2'd0, TRANSITION=2'd1, WON=2'd2.
  - WRAP_MODE constants: MODE_SATURATE=0, MODE_WRAP=1.
- One natural sub-module, sc_edge_detect_low:
  - Parametric reset value.
  - Holds adv_q and outputs the req pulse.
  - Reusable for other active-low game strobes.
- The FSM, timer and level register stay in the top module.

Test Plan:
- Reset/defaults: assert reset with advance held low, release → level=0, busy=0, win=0, levelup=0, and no advance occurs.
- Single advance: defaults; drive advance 1→0 and hold for 10 cycles → level becomes 1 at that edge, levelup high for 1 cycle, busy high for exactly 4 cycles, then one more toggle → level=2.
- Drop during busy: advance pulse, then a second falling edge 2 cycles later → level stays at +1 only, no second levelup.
- Saturate/win: WRAP_MODE=0, step to level 7, one further request → level stays 7, win=1, no levelup, state WON; further requests have no effect; clear → level=0, win=0.
- Wrap: WRAP_MODE=1, START_LEVEL=2, LEVEL_MAX=5, step from 2 to 5, one more request → level=2, levelup pulse, busy window, win stays 0.
- Clear vs request collision and mid-transition reset:
  - clear and req on the same edge → level=START_LEVEL, no levelup.
  - Reset asserted at busy cycle 2 → all outputs return to reset values asynchronously.
